// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the forwarding/hazard unit: forwarding select encodings and FSM states.
// Optional build macro WB_BYPASS_EN enables the IR5 (write-back) forwarding source.
package hazard_pkg;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_IR4 = 2'b01,
        FWD_IR3 = 2'b10,
        FWD_IR5 = 2'b11
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        TIMEOUT
    } hz_state_t;
endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side bundle of the forwarding/hazard unit; master = pipeline, slave = unit.
// With WB_BYPASS_EN defined the IR5 write-back destination is carried as well.
interface hazard_forward_unit_if
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
);
    logic [NUM_SRC*REG_AW-1:0] rs_IR2;
    logic [NUM_SRC-1:0]        rs_used_IR2;
    logic                      RegWrite_IR3;
    logic                      MemRead_IR3;
    logic [REG_AW-1:0]         instb_IR3;
    logic                      RegWrite_IR4;
    logic                      MemRead_IR4;
    logic [REG_AW-1:0]         instb_IR4;
`ifdef WB_BYPASS_EN
    logic                      RegWrite_IR5;
    logic [REG_AW-1:0]         instb_IR5;
`endif
    logic                      mem_ready;
    logic [2*NUM_SRC-1:0]      fwd_sel;
    logic                      stall_front;
    logic                      bubble_IR3;
    logic                      freeze_all;
    logic                      mem_timeout;
    logic [CNT_W-1:0]          stall_count;

    modport master (
        output rs_IR2, rs_used_IR2, RegWrite_IR3, MemRead_IR3, instb_IR3,
               RegWrite_IR4, MemRead_IR4, instb_IR4,
`ifdef WB_BYPASS_EN
               RegWrite_IR5, instb_IR5,
`endif
               mem_ready,
        input  fwd_sel, stall_front, bubble_IR3, freeze_all, mem_timeout, stall_count
    );

    modport slave (
        input  rs_IR2, rs_used_IR2, RegWrite_IR3, MemRead_IR3, instb_IR3,
               RegWrite_IR4, MemRead_IR4, instb_IR4,
`ifdef WB_BYPASS_EN
               RegWrite_IR5, instb_IR5,
`endif
               mem_ready,
        output fwd_sel, stall_front, bubble_IR3, freeze_all, mem_timeout, stall_count
    );
endinterface

// File: rtl/hazard_forward_unit_fwd_sel_one.sv
// Single-operand forwarding priority comparator: IR3 > IR4 (> IR5 with WB_BYPASS_EN) > register file.
// x0 and unread operands never forward.
module fwd_sel_one
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rs,
    input  logic              rs_used,
    input  logic              reg_write_ir3,
    input  logic [REG_AW-1:0] rd_ir3,
    input  logic              reg_write_ir4,
    input  logic [REG_AW-1:0] rd_ir4,
`ifdef WB_BYPASS_EN
    input  logic              reg_write_ir5,
    input  logic [REG_AW-1:0] rd_ir5,
`endif
    output fwd_sel_t          sel
);
    // rs != 0 together with rd == rs is the same as excluding rd == x0
    always_comb begin
        sel = FWD_RF;
        if (rs_used && (rs != '0)) begin
            if (reg_write_ir3 && (rd_ir3 == rs))
                sel = FWD_IR3;
            else if (reg_write_ir4 && (rd_ir4 == rs))
                sel = FWD_IR4;
`ifdef WB_BYPASS_EN
            else if (reg_write_ir5 && (rd_ir5 == rs))
                sel = FWD_IR5;
`endif
        end
    end
endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding and hazard unit: per-operand forwarding selects, load-use bubble, and a pipeline
// freeze FSM for slow data-memory loads with watchdog and stall counter. Option: WB_BYPASS_EN.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = REG_AW_DEF,
    parameter int NUM_SRC  = 2,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input logic                  clk,
    input logic                  reset,
    hazard_forward_unit_if.slave hz
);
    localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    hz_state_t            state;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [CNT_W-1:0]     stall_cnt;
    logic [2*NUM_SRC-1:0] fwd_raw;
    logic                 load_use;
    logic                 mem_miss;
    logic                 stall_raw;
    logic                 freeze_raw;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_op
        fwd_sel_t sel;
        fwd_sel_one #(.REG_AW(REG_AW)) u_sel (
            .rs            (hz.rs_IR2[gi*REG_AW +: REG_AW]),
            .rs_used       (hz.rs_used_IR2[gi]),
            .reg_write_ir3 (hz.RegWrite_IR3),
            .rd_ir3        (hz.instb_IR3),
            .reg_write_ir4 (hz.RegWrite_IR4),
            .rd_ir4        (hz.instb_IR4),
`ifdef WB_BYPASS_EN
            .reg_write_ir5 (hz.RegWrite_IR5),
            .rd_ir5        (hz.instb_IR5),
`endif
            .sel           (sel)
        );
        assign fwd_raw[2*gi +: 2] = sel;
    end

    always_comb begin
        load_use = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hz.rs_used_IR2[i] && (hz.rs_IR2[i*REG_AW +: REG_AW] == hz.instb_IR3))
                load_use = 1'b1;
        end
        load_use = load_use & hz.MemRead_IR3 & hz.RegWrite_IR3 & (hz.instb_IR3 != '0);
    end

    assign mem_miss = hz.MemRead_IR4 & ~hz.mem_ready;

    // Mealy outputs: freeze must drop in the very cycle mem_ready arrives, and freeze beats the bubble
    always_comb begin
        stall_raw  = 1'b0;
        freeze_raw = 1'b0;
        case (state)
            RUN: begin
                if (mem_miss)
                    freeze_raw = 1'b1;
                else if (load_use)
                    stall_raw = 1'b1;
            end
            MEM_WAIT: freeze_raw = ~hz.mem_ready;
            TIMEOUT:  freeze_raw = 1'b1;
            default:  freeze_raw = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if ((stall_raw | freeze_raw) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            case (state)
                RUN: begin
                    if (mem_miss) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (hz.mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                TIMEOUT: state <= TIMEOUT;
                default: state <= RUN;
            endcase
        end
    end

    // Outputs are held at zero for as long as reset is asserted
    assign hz.fwd_sel     = reset ? '0 : fwd_raw;
    assign hz.stall_front = stall_raw & ~reset;
    assign hz.bubble_IR3  = stall_raw & ~reset;
    assign hz.freeze_all  = freeze_raw & ~reset;
    assign hz.mem_timeout = (state == TIMEOUT) & ~reset;
    assign hz.stall_count = stall_cnt;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Testbench for hazard_forward_unit: directed scenarios plus random traffic against a behavioural model.
// Builds with or without WB_BYPASS_EN.
module tb_hazard_forward_unit;
    localparam int REG_AW   = 5;
    localparam int NUM_SRC  = 2;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 3;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    hazard_forward_unit_if #(.REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) hz ();

    hazard_forward_unit #(
        .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int vectors = 0;
    int miscompares = 0;

    // behavioural model: waiting flag, unready cycles seen in the current miss, sticky timeout, stall count
    bit m_wait, m_to;
    int m_miss, m_cnt;
    logic [3:0] e_fwd;
    logic e_stall, e_frz, e_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_sel(input int i);
        logic [REG_AW-1:0] r;
        r = hz.rs_IR2[i*REG_AW +: REG_AW];
        if (!hz.rs_used_IR2[i] || r == '0) return 2'b00;
        if (hz.RegWrite_IR3 && hz.instb_IR3 == r) return 2'b10;
        if (hz.RegWrite_IR4 && hz.instb_IR4 == r) return 2'b01;
`ifdef WB_BYPASS_EN
        if (hz.RegWrite_IR5 && hz.instb_IR5 == r) return 2'b11;
`endif
        return 2'b00;
    endfunction

    function automatic bit ref_load_use();
        bit hit = 0;
        for (int i = 0; i < NUM_SRC; i++)
            if (hz.rs_used_IR2[i] && hz.rs_IR2[i*REG_AW +: REG_AW] == hz.instb_IR3) hit = 1;
        return hit && hz.MemRead_IR3 && hz.RegWrite_IR3 && hz.instb_IR3 != '0;
    endfunction

    function automatic void ref_outputs();
        e_fwd = {ref_sel(1), ref_sel(0)};
        e_stall = 1'b0;
        e_frz = 1'b0;
        e_to = 1'b0;
        if (m_to) begin
            e_frz = 1'b1;
            e_to = 1'b1;
        end else if (m_wait) begin
            e_frz = !hz.mem_ready;
        end else if (hz.MemRead_IR4 && !hz.mem_ready) begin
            e_frz = 1'b1;
        end else if (ref_load_use()) begin
            e_stall = 1'b1;
        end
    endfunction

    function automatic void model_update();
        if ((e_stall || e_frz) && m_cnt < CNT_MAX) m_cnt++;
        if (!m_to) begin
            if (m_wait) begin
                if (hz.mem_ready) m_wait = 0;
                else begin
                    m_miss++;
                    if (m_miss == MAX_WAIT) begin
                        m_to = 1;
                        m_wait = 0;
                    end
                end
            end else if (hz.MemRead_IR4 && !hz.mem_ready) begin
                m_wait = 1;
                m_miss = 1;
            end
        end
    endfunction

    task automatic step(input string tag);
        @(negedge clk);
        ref_outputs();
        chk({tag, " fwd_sel"}, 32'(hz.fwd_sel), 32'(e_fwd));
        chk({tag, " stall_front"}, 32'(hz.stall_front), 32'(e_stall));
        chk({tag, " bubble_IR3"}, 32'(hz.bubble_IR3), 32'(e_stall));
        chk({tag, " freeze_all"}, 32'(hz.freeze_all), 32'(e_frz));
        chk({tag, " mem_timeout"}, 32'(hz.mem_timeout), 32'(e_to));
        chk({tag, " stall_count"}, 32'(hz.stall_count), 32'(m_cnt));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic expect_now(input string tag, input logic [3:0] f, input logic s,
                              input logic fr, input logic to, input logic [CNT_W-1:0] c);
        #1;
        chk({tag, " fwd_sel(const)"}, 32'(hz.fwd_sel), 32'(f));
        chk({tag, " stall_front(const)"}, 32'(hz.stall_front), 32'(s));
        chk({tag, " bubble_IR3(const)"}, 32'(hz.bubble_IR3), 32'(s));
        chk({tag, " freeze_all(const)"}, 32'(hz.freeze_all), 32'(fr));
        chk({tag, " mem_timeout(const)"}, 32'(hz.mem_timeout), 32'(to));
        chk({tag, " stall_count(const)"}, 32'(hz.stall_count), 32'(c));
    endtask

    task automatic do_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        chk({tag, " rst fwd_sel"}, 32'(hz.fwd_sel), 32'd0);
        chk({tag, " rst stall_front"}, 32'(hz.stall_front), 32'd0);
        chk({tag, " rst bubble_IR3"}, 32'(hz.bubble_IR3), 32'd0);
        chk({tag, " rst freeze_all"}, 32'(hz.freeze_all), 32'd0);
        chk({tag, " rst mem_timeout"}, 32'(hz.mem_timeout), 32'd0);
        chk({tag, " rst stall_count"}, 32'(hz.stall_count), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        m_wait = 0;
        m_to = 0;
        m_miss = 0;
        m_cnt = 0;
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs0, input logic [1:0] used,
                         input logic rw3, input logic mr3, input logic [4:0] rd3,
                         input logic rw4, input logic mr4, input logic [4:0] rd4, input logic rdy);
        hz.rs_IR2 = {rs1, rs0};
        hz.rs_used_IR2 = used;
        hz.RegWrite_IR3 = rw3;
        hz.MemRead_IR3 = mr3;
        hz.instb_IR3 = rd3;
        hz.RegWrite_IR4 = rw4;
        hz.MemRead_IR4 = mr4;
        hz.instb_IR4 = rd4;
        hz.mem_ready = rdy;
`ifdef WB_BYPASS_EN
        hz.RegWrite_IR5 = 1'b0;
        hz.instb_IR5 = 5'd0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        do_reset("init");

        // forwarding priorities and x0
        drive(5'd6, 5'd5, 2'b11, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd6, 1'b1);
        expect_now("fwd_both", 4'b0110, 1'b0, 1'b0, 1'b0, 3'd0);
        step("fwd_both");
        drive(5'd0, 5'd7, 2'b01, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1);
        expect_now("ir3_wins", 4'b0010, 1'b0, 1'b0, 1'b0, 3'd0);
        step("ir3_wins");
        drive(5'd0, 5'd0, 2'b01, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1);
        expect_now("x0", 4'b0000, 1'b0, 1'b0, 1'b0, 3'd0);
        step("x0");

        // load-use bubble, then forward from IR4
        drive(5'd9, 5'd1, 2'b11, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 1'b1);
        expect_now("load_use", 4'b1000, 1'b1, 1'b0, 1'b0, 3'd0);
        step("load_use");
        drive(5'd9, 5'd1, 2'b11, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1);
        expect_now("after_bubble", 4'b0100, 1'b0, 1'b0, 1'b0, 3'd1);
        step("after_bubble");
        drive(5'd9, 5'd1, 2'b01, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 1'b1);
        expect_now("unused_rs", 4'b0000, 1'b0, 1'b0, 1'b0, 3'd1);
        step("unused_rs");

        // miss with a pending load-use: freeze only, bubble deferred until back in RUN
        do_reset("pre_miss");
        drive(5'd9, 5'd1, 2'b11, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 5'd4, 1'b0);
        for (int k = 0; k < 3; k++) begin
            expect_now("miss_wait", 4'b1000, 1'b0, 1'b1, 1'b0, 3'(k));
            step("miss_wait");
        end
        hz.mem_ready = 1'b1;
        expect_now("miss_ready", 4'b1000, 1'b0, 1'b0, 1'b0, 3'd3);
        step("miss_ready");
        drive(5'd9, 5'd1, 2'b11, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 5'd0, 1'b1);
        expect_now("deferred_bubble", 4'b1000, 1'b1, 1'b0, 1'b0, 3'd3);
        step("deferred_bubble");

        // watchdog timeout, counter saturation, async reset mid-TIMEOUT
        do_reset("pre_timeout");
        drive(5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd4, 1'b0);
        for (int k = 0; k < MAX_WAIT; k++) begin
            expect_now("to_wait", 4'b0000, 1'b0, 1'b1, 1'b0, 3'(k));
            step("to_wait");
        end
        hz.mem_ready = 1'b1;
        for (int k = 4; k < 9; k++) begin
            expect_now("timeout", 4'b0000, 1'b0, 1'b1, 1'b1, 3'((k > CNT_MAX) ? CNT_MAX : k));
            step("timeout");
        end
        drive(5'd0, 5'd3, 2'b01, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0);
        do_reset("mid_timeout");
        expect_now("after_reset", 4'b0010, 1'b0, 1'b0, 1'b0, 3'd0);
        step("after_reset");

`ifdef WB_BYPASS_EN
        drive(5'd0, 5'd3, 2'b01, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1);
        hz.RegWrite_IR5 = 1'b1;
        hz.instb_IR5 = 5'd3;
        expect_now("ir5_only", 4'b0011, 1'b0, 1'b0, 1'b0, 3'd0);
        step("ir5_only");
        hz.RegWrite_IR4 = 1'b1;
        hz.instb_IR4 = 5'd3;
        expect_now("ir4_beats_ir5", 4'b0001, 1'b0, 1'b0, 1'b0, 3'd0);
        step("ir4_beats_ir5");
`endif

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            if (m_to && $urandom_range(0, 3) == 0) do_reset("rand_reset");
            hz.rs_IR2 = {REG_AW'($urandom_range(0, 7)), REG_AW'($urandom_range(0, 7))};
            hz.rs_used_IR2 = 2'($urandom_range(0, 3));
            hz.RegWrite_IR3 = 1'($urandom_range(0, 1));
            hz.MemRead_IR3 = 1'($urandom_range(0, 1));
            hz.instb_IR3 = REG_AW'($urandom_range(0, 7));
            hz.RegWrite_IR4 = 1'($urandom_range(0, 1));
            hz.MemRead_IR4 = ($urandom_range(0, 9) < 3);
            hz.instb_IR4 = REG_AW'($urandom_range(0, 7));
            hz.mem_ready = ($urandom_range(0, 3) != 0);
`ifdef WB_BYPASS_EN
            hz.RegWrite_IR5 = 1'($urandom_range(0, 1));
            hz.instb_IR5 = REG_AW'($urandom_range(0, 7));
`endif
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
